// File: rtl/uart_phy.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_phy
//   Serial UART line engine sitting behind the AHB-to-UART bridge.
//   TX serialises one byte per tx_valid/tx_ready handshake onto uart_txd.
//   RX deserialises uart_rxd and delivers each byte with a one-cycle pulse.
//   Frame format is 8N1 by default; defining the macro UART_PARITY_EN
//   switches both directions to 8E1 (even parity bit between bit 7 and stop).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//
// Ports
//   clk           in   system clock, rising edge
//   rstn          in   asynchronous active-low reset
//   tx_valid      in   byte on tx_data is offered
//   tx_ready      out  TX idle, a byte may be handed over this cycle
//   tx_data       in   byte to transmit, sampled on the handshake cycle
//   rx_ready      in   consumer enable; 0 discards received bytes
//   rx_valid      out  one-cycle pulse, rx_data holds a new byte
//   rx_data       out  last delivered byte
//   rx_drop       out  one-cycle pulse, good byte discarded (rx_ready=0)
//   rx_frame_err  out  one-cycle pulse, bad stop (or parity) bit, byte discarded
//   uart_txd      out  serial output, idles high
//   uart_rxd      in   serial input, asynchronous to clk
// -----------------------------------------------------------------------------
module uart_phy #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_drop,
  output logic       rx_frame_err,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // TX state
  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q,   tx_cnt_d;
  logic [2:0]      tx_bit_q,   tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q,      txd_d;
  logic            tx_ready_q, tx_ready_d;
  logic            tx_bit_end;
`ifdef UART_PARITY_EN
  logic            tx_par_q,   tx_par_d;
`endif

  // RX state
  logic            rxd_meta_q, rxd_meta_d;
  logic            rxd_s_q,    rxd_s_d;
  logic            rxd_prev_q, rxd_prev_d;
  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
  logic [2:0]      rx_bit_q,   rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q,  rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_drop_q,  rx_drop_d;
  logic            rx_err_q,   rx_err_d;
  logic            rx_brk_q,   rx_brk_d;
  logic            rx_bit_end;
  logic            rx_par_bad;
`ifdef UART_PARITY_EN
  logic            rx_par_err_q, rx_par_err_d;
  assign rx_par_bad = rx_par_err_q;
`else
  assign rx_par_bad = 1'b0;
`endif

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  // TX next state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_ready_d = tx_ready_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q != S_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    end
    case (tx_state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          tx_shift_d = tx_data;
`ifdef UART_PARITY_EN
          tx_par_d   = even_par(tx_data);
`endif
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            txd_d      = tx_par_q;
            tx_state_d = S_PARITY;
`else
            txd_d      = 1'b1;
            tx_state_d = S_STOP;
`endif
          end else begin
            // Next bit is the one just above the bit being driven now.
            txd_d      = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tx_bit_end) begin
          txd_d      = 1'b1;
          tx_state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tx_bit_end) begin
          txd_d      = 1'b1;
          tx_ready_d = 1'b1;
          tx_state_d = S_IDLE;
        end
      end
      default: begin
        txd_d      = 1'b1;
        tx_ready_d = 1'b1;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  // RX next state
  always_comb begin
    rxd_meta_d = uart_rxd;
    rxd_s_d    = rxd_meta_q;
    rxd_prev_d = rxd_s_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_brk_d   = rx_brk_q;
    rx_valid_d = 1'b0;
    rx_drop_d  = 1'b0;
    rx_err_d   = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (rx_state_q)
      S_IDLE: begin
        if (rx_brk_q) begin
          // After a low stop bit, wait for the line to recover before arming.
          if (rxd_s_q) rx_brk_d = 1'b0;
        end else if (rxd_prev_q && !rxd_s_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rxd_s_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_bit_d   = 3'd0;
`ifdef UART_PARITY_EN
            rx_par_err_d = 1'b0;
`endif
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = S_PARITY;
`else
            rx_state_d = S_STOP;
`endif
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d     = '0;
          rx_par_err_d = (rxd_s_q != even_par(rx_shift_q));
          rx_state_d   = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rxd_s_q && !rx_par_bad) begin
            if (rx_ready) begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_drop_d  = 1'b1;
            end
          end else begin
            rx_err_d = 1'b1;
            rx_brk_d = !rxd_s_q;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_par_err_q <= 1'b0;
`endif
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_drop_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_par_err_q <= rx_par_err_d;
`endif
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
      rxd_prev_q <= rxd_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_drop_q  <= rx_drop_d;
      rx_err_q   <= rx_err_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  assign tx_ready     = tx_ready_q;
  assign uart_txd     = txd_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_drop      = rx_drop_q;
  assign rx_frame_err = rx_err_q;

endmodule
